// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Request/response bundle between the memory stage of the pipelined datapath
// and the data-memory responder.
//
// Signals
//   req_valid   requester -> responder : request present this cycle
//   req_we      requester -> responder : 1 = store, 0 = load
//   req_byte    requester -> responder : 1 = byte access, 0 = word access
//   req_addr    requester -> responder : byte address
//   req_wdata   requester -> responder : store data (byte stores use [7:0])
//   busy        responder -> requester : request in flight, stall the pipe
//   resp_valid  responder -> requester : one-cycle response pulse
//   resp_rdata  responder -> requester : load data, held between responses
//   resp_err    responder -> requester : qualifies resp_valid (range/alignment)
//
// Modports: master (requester side), slave (responder side).
// -----------------------------------------------------------------------------
interface dmem_if;
    logic        req_valid;
    logic        req_we;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata,
        input  busy, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata,
        output busy, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Word-organised data RAM with a fixed access latency, serving the memory
// stage's loads and stores over a valid/busy handshake. busy feeds the hazard
// unit's stall. Byte loads return the selected byte zero-extended in
// resp_rdata[7:0] for the writeback sign-extender.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 4)
//   LATENCY  cycles from acceptance to response (1..15)
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (RAM contents are retained)
//   bus    dmem_if.slave : req_* in, busy/resp_* out
//
// Build option
//   DMEM_BYTE_EN  defined   : byte loads/stores honoured via req_byte
//                 undefined : req_byte ignored, every access is a word access
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        busy_q;
    logic        resp_valid_q;
    logic [31:0] mem_q [DEPTH];

    logic             accept_s;
    logic             access_s;
    logic             mem_we_s;
    logic [31:0]      mem_wdata_s;
    logic [IDX_W-1:0] idx_s;
    logic             in_range_s;
    logic             misalign_s;
    logic [31:0]      cur_word_s;

`ifdef DMEM_BYTE_EN
    logic byte_q;

    // Little-endian lane extract: lane 0 is bits [7:0], lane 3 is [31:24].
    function automatic logic [7:0] get_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Replace one lane of a word, leaving the other three untouched.
    function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (lane)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w = word;
        endcase
        return w;
    endfunction

    // Byte accesses are never misaligned; word accesses need addr[1:0]==0.
    assign misalign_s = !byte_q && (addr_q[1:0] != 2'b00);
`else
    // req_byte has no meaning in a word-only build.
    logic unused_byte_s;
    assign unused_byte_s = bus.req_byte;
    assign misalign_s    = (addr_q[1:0] != 2'b00);
`endif

    // DEPTH is a power of two, so any set bit above the index field is out of range.
    assign idx_s      = addr_q[IDX_W+1:2];
    assign in_range_s = (addr_q[31:IDX_W+2] == '0);
    assign cur_word_s = mem_q[idx_s];

    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Next-state logic: accept in IDLE/RESP, count down in WAIT, access on zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        access_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    cnt_d    = 4'(LATENCY - 1);
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access_s = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    cnt_d    = 4'(LATENCY - 1);
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Access datapath: response data/error and RAM write for the latched request.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_wdata_s = cur_word_s;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (access_s) begin
            if (!in_range_s || misalign_s) begin
                // Errored accesses never touch the RAM and return zero.
                err_d   = 1'b1;
                rdata_d = 32'h0000_0000;
            end else begin
                err_d = 1'b0;
`ifdef DMEM_BYTE_EN
                if (byte_q) begin
                    if (we_q) begin
                        mem_we_s    = 1'b1;
                        mem_wdata_s = put_lane(cur_word_s, addr_q[1:0], wdata_q[7:0]);
                        rdata_d     = {24'h000000, wdata_q[7:0]};
                    end else begin
                        rdata_d     = {24'h000000, get_lane(cur_word_s, addr_q[1:0])};
                    end
                end else
`endif
                begin
                    if (we_q) begin
                        mem_we_s    = 1'b1;
                        mem_wdata_s = wdata_q;
                        rdata_d     = wdata_q;
                    end else begin
                        rdata_d     = cur_word_s;
                    end
                end
            end
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Control/response registers; handshake outputs are registered from next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            busy_q       <= (state_d == ST_WAIT);
            resp_valid_q <= (state_d == ST_RESP);
            if (accept_s) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end else begin
                we_q    <= we_q;
                addr_q  <= addr_q;
                wdata_q <= wdata_q;
            end
        end
    end

`ifdef DMEM_BYTE_EN
    // Byte-access flag latched alongside the rest of the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_q <= 1'b0;
        end else if (accept_s) begin
            byte_q <= bus.req_byte;
        end else begin
            byte_q <= byte_q;
        end
    end
`endif

    // RAM array: no reset so contents survive a reset; a reset during WAIT
    // forces IDLE asynchronously, which suppresses the pending write.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_s] <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;
`ifdef DMEM_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [31:0] model_mem [DEPTH];

    dmem_if bus ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: serialised accesses on an array of words.
    function automatic void model_access(input logic we, input logic bt, input logic [31:0] addr,
                                         input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int unsigned idx;
        int unsigned lane;
        bit as_byte;
        idx     = addr / 4;
        lane    = addr % 4;
        as_byte = BYTE_EN && bt;
        rd  = 32'h0;
        err = 1'b0;
        if (idx >= DEPTH || (!as_byte && lane != 0)) begin
            err = 1'b1;
        end else if (as_byte) begin
            if (we) begin
                model_mem[idx][8*lane +: 8] = wd[7:0];
                rd = {24'h0, wd[7:0]};
            end else begin
                rd = {24'h0, model_mem[idx][8*lane +: 8]};
            end
        end else if (we) begin
            model_mem[idx] = wd;
            rd = wd;
        end else begin
            rd = model_mem[idx];
        end
    endfunction

    // One isolated request: checks latency, busy length, response and pulse width.
    task automatic txn(input logic we, input logic bt, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag,
                       output logic [31:0] obs_rd, output logic obs_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int n;
        int busy_n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_byte  = bt;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        busy_n = 0;
        while (n < LAT + 5 && !bus.resp_valid) begin
            if (bus.busy) busy_n++;
            @(posedge clk);
            #1;
            n++;
        end
        model_access(we, bt, addr, wd, exp_rd, exp_err);
        obs_rd  = bus.resp_rdata;
        obs_err = bus.resp_err;
        chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, ".latency"}, n, LAT);
        chk({tag, ".busy_cycles"}, busy_n, LAT);
        chk({tag, ".rdata"}, bus.resp_rdata, exp_rd);
        chk({tag, ".err"}, 32'(bus.resp_err), 32'(exp_err));
        @(posedge clk);
        #1;
        chk({tag, ".pulse_end"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] old_w;
        logic [31:0] a_data;
        logic [31:0] e_rd;
        logic        e_er;
        int c0;
        int p1;
        int p2;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        reset = 1'b0;
        #1;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset.rdata", bus.resp_rdata, 32'd0);
        chk("reset.err", 32'(bus.resp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed plan
        txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, "st_w10", rd, er);
        chk("st_w10.const_err", 32'(er), 32'd0);
        txn(1'b0, 1'b0, 32'h10, 32'h0, "ld_w10", rd, er);
        chk("ld_w10.const", rd, 32'hDEADBEEF);
        txn(1'b0, 1'b1, 32'h13, 32'h0, "ld_b13", rd, er);
`ifdef DMEM_BYTE_EN
        chk("ld_b13.const", rd, 32'h000000DE);
`endif
        txn(1'b1, 1'b1, 32'h11, 32'h55, "st_b11", rd, er);
        txn(1'b0, 1'b0, 32'h10, 32'h0, "ld_w10b", rd, er);
`ifdef DMEM_BYTE_EN
        chk("ld_w10b.const", rd, 32'hDEAD55EF);
`endif
        txn(1'b0, 1'b0, 32'h102, 32'h0, "ld_mis", rd, er);
        chk("ld_mis.const_err", 32'(er), 32'd1);
        chk("ld_mis.const_rd", rd, 32'd0);

        // Fill the remaining words so every later load has a known value.
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 4) txn(1'b1, 1'b0, 32'(i * 4), $urandom, "fill", rd, er);
        end
        old_w = model_mem[0];
        txn(1'b1, 1'b0, 32'h100, 32'h12345678, "st_oor", rd, er);
        chk("st_oor.const_err", 32'(er), 32'd1);
        txn(1'b0, 1'b0, 32'h0, 32'h0, "ld_w0", rd, er);
        chk("ld_w0.unchanged", rd, old_w);

        // Reset during WAIT drops the pending store and its response.
        old_w = model_mem[8];
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 32'h20;
        bus.req_wdata = ~old_w;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("rstw.busy_before", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstw.busy", 32'(bus.busy), 32'd0);
        chk("rstw.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rstw.rdata", bus.resp_rdata, 32'd0);
        chk("rstw.err", 32'(bus.resp_err), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("rstw.no_pulse_in", 32'(bus.resp_valid), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            @(posedge clk);
            #1;
            chk("rstw.no_pulse_after", 32'(bus.resp_valid), 32'd0);
        end
        txn(1'b0, 1'b0, 32'h20, 32'h0, "rstw.reload", rd, er);
        chk("rstw.old_kept", rd, old_w);

        // Back-to-back: second request accepted in the RESP cycle.
        a_data = $urandom;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 32'h30;
        bus.req_wdata = a_data;
        @(posedge clk);
        #1;
        c0 = cyc;
        p1 = -1;
        p2 = -1;
        for (int k = 0; k < 4 * LAT + 10 && p2 < 0; k++) begin
            if (bus.resp_valid) begin
                if (p1 < 0) begin
                    p1 = cyc;
                    model_access(1'b1, 1'b0, 32'h30, a_data, e_rd, e_er);
                    chk("b2b.rd1", bus.resp_rdata, e_rd);
                    bus.req_we = 1'b0;
                end else begin
                    p2 = cyc;
                    model_access(1'b0, 1'b0, 32'h30, 32'h0, e_rd, e_er);
                    chk("b2b.rd2", bus.resp_rdata, e_rd);
                    chk("b2b.rd2_const", bus.resp_rdata, a_data);
                end
            end else if (p1 >= 0) begin
                bus.req_valid = 1'b0;
            end
            if (p2 < 0) begin
                @(posedge clk);
                #1;
            end
        end
        bus.req_valid = 1'b0;
        chk("b2b.first_lat", p1 - c0, LAT);
        chk("b2b.spacing", p2 - p1, LAT + 1);
        @(posedge clk);
        #1;
        chk("b2b.pulse_end", 32'(bus.resp_valid), 32'd0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            ra = $urandom_range(0, 4 * DEPTH + 7);
            if ($urandom_range(0, 7) == 0) ra = ra | 32'h8000_0000;
            txn(1'($urandom), 1'($urandom), ra, $urandom, "rand", rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipelined datapath's memory-stage load/store requests.
- Word-organised RAM with a configurable fixed access latency.
- Valid/busy handshake; busy drives the hazard unit's stall.
- Byte loads return the selected byte in rdata[7:0] so the writeback byte sign-extender can consume it directly.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, >= 4.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present this cycle
- req_we  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access (lb/sb), 0 = word access
- req_addr  in  32  byte address (aluoutM)
- req_wdata  in  32  store data (writedataM); byte stores use [7:0]
- busy  out  1  request in flight; new requests not accepted
- resp_valid  out  1  one-cycle response/ack pulse
- resp_rdata  out  32  load data (readdataM); held between responses
- resp_err  out  1  qualifies resp_valid: out-of-range or misaligned access

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - RAM contents are not reset and are retained across reset.
- FSM states: IDLE, WAIT, RESP.
  - busy = (state==WAIT).
  - Acceptance when req_valid=1 in IDLE or RESP: latch we/byte/addr/wdata, counter <= LATENCY-1, go WAIT.
  - WAIT, counter!=0: decrement.
  - WAIT, counter==0: perform access, go RESP.
  - RESP: resp_valid=1 for exactly this cycle. With req_valid=0, go IDLE; with req_valid=1, accept back-to-back.
- Latency: request sampled at edge E0 gives resp_valid high in the cycle after edge E0+LATENCY.
  - LATENCY=1: one WAIT cycle, then RESP.
  - Peak throughput: one access per LATENCY+1 cycles.
- req_* are ignored while busy=1; the requester holds them stable under stall.
- Word index = addr[31:2].
  - Out of range when addr[31:2] >= DEPTH: resp_err=1, load returns 0, store dropped.
- Word access with addr[1:0]!=0 is misaligned: resp_err=1, no RAM change, rdata=0.
- Word load: rdata = mem[idx].
- Word store: mem[idx] <= wdata; rdata on the ack = wdata.
- Byte load: rdata = {24'b0, lane}, where lane addr[1:0]=0 selects bits [7:0] and lane 3 selects bits [31:24] (little-endian).
- Byte store: only the addressed lane is updated from wdata[7:0]; other lanes are unchanged.
- Store followed by load to the same address returns the new data; there is no read-before-write hazard because the accesses are serialised.
- resp_rdata and resp_err hold their values until the next RESP. resp_err is cleared on each acceptance-free RESP with no error.
- Reset asserted while in WAIT: a pending store is not performed and no resp_valid pulse is issued.

Optional Feature:
- Macro DMEM_BYTE_EN.
- Defined: byte loads and stores as specified above.
- Undefined: req_byte is ignored and every access is treated as a word access, including the misalignment check. No byte-lane logic is synthesised.

Test Plan:
- Reset, then word store addr=0x10, wdata=0xDEADBEEF (LATENCY=2):
  - busy=1 for 2 cycles after acceptance.
  - resp_valid pulses once with resp_err=0.
- Word load addr=0x10 -> resp_rdata=0xDEADBEEF after the same latency.
- Byte load addr=0x13 -> rdata=0x000000DE.
- Byte store addr=0x11, wdata=0x55, then word load 0x10 -> 0xDEAD55EF.
- Word load addr=0x102 (misaligned) -> resp_err=1, rdata=0.
- Word store addr=0x100 (idx 64 >= DEPTH) -> resp_err=1; word 0 unchanged.
- Store issued, reset pulsed during WAIT, then reload:
  - No resp_valid during or after the reset.
  - Target word keeps its old value.
  - Outputs read 0 during reset.
- Back-to-back: req_valid held high across the RESP cycle -> second request accepted in RESP; resp_valid pulses are spaced LATENCY+1 cycles apart.
